// File: rtl/arrow_lanes.sv
// Falling-arrow rhythm lanes: per-lane IDLE/FALL/FLASH state, hit/miss scoring, registered pixel.
// Optional macro ARROW_LANES_MISS_PENALTY_EN: a key edge outside the hit window counts as a miss.
module arrow_lanes #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned LANE_X0 = 160,
  parameter int unsigned LANE_W  = 64,
  parameter int unsigned ARROW_H = 40,
  parameter int unsigned TOP_Y   = 31,
  parameter int unsigned SPEED   = 2,
  parameter int unsigned HIT_Y   = 440,
  parameter int unsigned HIT_WIN = 16
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic [9:0]       hc,
  input  logic [9:0]       vc,
  input  logic             frame_tick,
  input  logic [LANES-1:0] spawn,
  input  logic [LANES-1:0] key,
  output logic [2:0]       red,
  output logic [2:0]       green,
  output logic [1:0]       blue,
  output logic             hit_pulse,
  output logic             miss_pulse,
  output logic [7:0]       score
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFall  = 2'd1;
  localparam logic [1:0] StFlash = 2'd2;

  localparam logic [10:0] WinLo = 11'(HIT_Y - HIT_WIN);
  localparam logic [10:0] WinHi = 11'(HIT_Y + HIT_WIN);

  logic [1:0]       st_q [LANES];
  logic [1:0]       st_d [LANES];
  logic [9:0]       y_q  [LANES];
  logic [9:0]       y_d  [LANES];
  logic [2:0]       fc_q [LANES];
  logic [2:0]       fc_d [LANES];
  logic [LANES-1:0] key_q;
  logic [LANES-1:0] hit, pen, drop;
  logic [10:0]      ny;
  logic             kedge, in_win;
  logic [3:0]       n_hit, n_pen;
  logic [9:0]       up;
  logic [7:0]       score_q, score_d;
  logic [7:0]       pix_q, pix_d;

  // Lane state machines
  always_comb begin
    ny     = '0;
    kedge  = 1'b0;
    in_win = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      st_d[i] = st_q[i];
      y_d[i]  = y_q[i];
      fc_d[i] = fc_q[i];
      hit[i]  = 1'b0;
      pen[i]  = 1'b0;
      drop[i] = 1'b0;
      ny      = {1'b0, y_q[i]} + 11'(SPEED);
      kedge   = key[i] & ~key_q[i];
      in_win  = ({1'b0, y_q[i]} >= WinLo) && ({1'b0, y_q[i]} <= WinHi);
      case (st_q[i])
        StIdle: begin
          // spawn beats a coincident frame_tick: no advance on the spawn frame
          if (spawn[i]) begin
            st_d[i] = StFall;
            y_d[i]  = 10'(TOP_Y);
          end
        end
        StFall: begin
          // hit check uses the pre-advance position
          if (kedge && in_win) begin
            st_d[i] = StFlash;
            fc_d[i] = 3'd7;
            hit[i]  = 1'b1;
          end
`ifdef ARROW_LANES_MISS_PENALTY_EN
          else if (kedge) begin
            st_d[i] = StIdle;
            pen[i]  = 1'b1;
          end
`endif
          else if (frame_tick) begin
            if (ny > WinHi) begin
              st_d[i] = StIdle;
              drop[i] = 1'b1;
            end else if (ny > 11'd1023) begin
              y_d[i] = 10'd1023;
            end else begin
              y_d[i] = ny[9:0];
            end
          end
        end
        StFlash: begin
          if (frame_tick) begin
            if (fc_q[i] == 3'd0) st_d[i] = StIdle;
            else                 fc_d[i] = fc_q[i] - 3'd1;
          end
        end
        default: st_d[i] = StIdle;
      endcase
    end
  end

  // Saturating score: hits add, penalty misses subtract, fall-off misses leave it alone
  always_comb begin
    n_hit = '0;
    n_pen = '0;
    for (int i = 0; i < LANES; i++) begin
      n_hit = n_hit + 4'(hit[i]);
      n_pen = n_pen + 4'(pen[i]);
    end
    up = {2'b00, score_q} + {6'd0, n_hit};
    if (up < {6'd0, n_pen})            score_d = 8'd0;
    else if (up - {6'd0, n_pen} > 255) score_d = 8'd255;
    else                               score_d = 8'(up - {6'd0, n_pen});
  end

  // Pixel: falling arrow > flash band > target line > black
  logic [31:0] hc32, vc32, y32, xl;
  logic        in_x, fall_any, flash_any, grey_any;
  logic [7:0]  fall_col;
  always_comb begin
    hc32      = {22'd0, hc};
    vc32      = {22'd0, vc};
    y32       = '0;
    xl        = '0;
    in_x      = 1'b0;
    fall_any  = 1'b0;
    flash_any = 1'b0;
    grey_any  = 1'b0;
    fall_col  = 8'h00;
    for (int i = 0; i < LANES; i++) begin
      xl   = LANE_X0 + LANE_W * unsigned'(i);
      y32  = {22'd0, y_q[i]};
      in_x = (hc32 >= xl) && (hc32 < xl + LANE_W);
      if (!fall_any && st_q[i] == StFall && in_x && vc32 >= y32 &&
          vc32 <= y32 + ARROW_H - 1) begin
        fall_any = 1'b1;
        case (2'(i))
          2'd0:    fall_col = 8'b111_000_00;
          2'd1:    fall_col = 8'b000_111_00;
          2'd2:    fall_col = 8'b000_000_11;
          default: fall_col = 8'b111_111_00;
        endcase
      end
      if (st_q[i] == StFlash && in_x && vc32 + 2 >= HIT_Y && vc32 <= HIT_Y + 2) flash_any = 1'b1;
      if (in_x && vc32 == HIT_Y) grey_any = 1'b1;
    end
    if (fall_any)       pix_d = fall_col;
    else if (flash_any) pix_d = 8'b111_111_11;
    else if (grey_any)  pix_d = 8'b011_011_01;
    else                pix_d = 8'h00;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) begin
        st_q[i] <= StIdle;
        y_q[i]  <= '0;
        fc_q[i] <= '0;
      end
      key_q      <= '1;  // a key held through reset must not look like a press
      pix_q      <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score_q    <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        st_q[i] <= st_d[i];
        y_q[i]  <= y_d[i];
        fc_q[i] <= fc_d[i];
      end
      key_q      <= key;
      pix_q      <= pix_d;
      hit_pulse  <= |hit;
      miss_pulse <= |(pen | drop);
      score_q    <= score_d;
    end
  end

  assign {red, green, blue} = pix_q;
  assign score              = score_q;

endmodule

// File: tb/tb_arrow_lanes.sv
// Directed bench for arrow_lanes: pixel vector table plus hand-written hit/miss/reset sequences.
module tb_arrow_lanes;

  logic       sclk = 1'b0;
  logic       rst_n;
  logic [9:0] hc, vc;
  logic       frame_tick;
  logic [3:0] spawn, key;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       hit_pulse, miss_pulse;
  logic [7:0] score;

  // Second instance spawning inside the hit window, used to drive the score to saturation quickly
  logic       f_tick;
  logic [3:0] f_spawn, f_key;
  logic [2:0] f_red, f_green;
  logic [1:0] f_blue;
  logic       f_hit, f_miss;
  logic [7:0] f_score;

  int n_chk = 0;
  int n_err = 0;
  logic saw_miss;
  logic exp_miss;
  logic [7:0] exp_pix;

  always #5 sclk = ~sclk;

  arrow_lanes u_dut (
    .sclk(sclk), .rst_n(rst_n), .hc(hc), .vc(vc), .frame_tick(frame_tick),
    .spawn(spawn), .key(key), .red(red), .green(green), .blue(blue),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score)
  );

  arrow_lanes #(.TOP_Y(440)) u_fast (
    .sclk(sclk), .rst_n(rst_n), .hc(10'd0), .vc(10'd0), .frame_tick(f_tick),
    .spawn(f_spawn), .key(f_key), .red(f_red), .green(f_green), .blue(f_blue),
    .hit_pulse(f_hit), .miss_pulse(f_miss), .score(f_score)
  );

  typedef struct {
    logic [9:0] hc;
    logic [9:0] vc;
    logic [7:0] rgb;
  } pix_vec_t;

  pix_vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sclk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      cyc();
      if (miss_pulse) saw_miss = 1'b1;
      frame_tick = 1'b0;
      cyc();
      if (miss_pulse) saw_miss = 1'b1;
    end
  endtask

  task automatic fast_round(input logic [3:0] mask);
    f_spawn = mask;
    cyc();
    f_spawn = '0;
    f_key   = mask;
    cyc();
    f_key  = '0;
    f_tick = 1'b1;
    repeat (8) cyc();
    f_tick = 1'b0;
    cyc();
  endtask

  initial begin
    // lanes 2 and 3 falling with top edge at y=201
    vecs[0]  = '{10'd352, 10'd201, 8'hFC};
    vecs[1]  = '{10'd352, 10'd200, 8'h00};
    vecs[2]  = '{10'd352, 10'd240, 8'hFC};
    vecs[3]  = '{10'd352, 10'd241, 8'h00};
    vecs[4]  = '{10'd415, 10'd220, 8'hFC};
    vecs[5]  = '{10'd416, 10'd220, 8'h00};
    vecs[6]  = '{10'd351, 10'd220, 8'h03};
    vecs[7]  = '{10'd288, 10'd201, 8'h03};
    vecs[8]  = '{10'd287, 10'd201, 8'h00};
    vecs[9]  = '{10'd160, 10'd440, 8'h6D};
    vecs[10] = '{10'd159, 10'd440, 8'h00};
    vecs[11] = '{10'd415, 10'd440, 8'h6D};
    vecs[12] = '{10'd416, 10'd440, 8'h00};
    vecs[13] = '{10'd200, 10'd439, 8'h00};

    rst_n = 1'b0; hc = '0; vc = '0; frame_tick = 1'b0; spawn = '0; key = '0;
    f_tick = 1'b0; f_spawn = '0; f_key = '0; saw_miss = 1'b0;
    repeat (2) cyc();
    chk("reset_rgb", {red, green, blue}, 8'h00);
    chk("reset_score", score, 8'd0);
    chk("reset_strobes", {hit_pulse, miss_pulse}, 2'b00);
    rst_n = 1'b1;
    cyc();

    // Lanes 2,3 spawned; 85 frames -> y=201
    spawn = 4'b1100;
    cyc();
    spawn = '0;
    frames(85);
    for (int v = 0; v < 14; v++) begin
      hc = vecs[v].hc;
      vc = vecs[v].vc;
      cyc();
      chk($sformatf("pix_vec%0d", v), {red, green, blue}, vecs[v].rgb);
    end

    // 15 more frames -> y=231, key lane 2 outside window
    frames(15);
`ifdef ARROW_LANES_MISS_PENALTY_EN
    exp_miss = 1'b1; exp_pix = 8'h00;
`else
    exp_miss = 1'b0; exp_pix = 8'h03;
`endif
    key[2] = 1'b1;
    cyc();
    chk("early_key_hit", hit_pulse, 1'b0);
    chk("early_key_miss", miss_pulse, exp_miss);
    chk("early_key_score", score, 8'd0);
    key = '0;
    hc = 10'd300; vc = 10'd231;
    cyc();
    chk("early_key_lane2", {red, green, blue}, exp_pix);
    hc = 10'd352;
    cyc();
    chk("lane3_before_rst", {red, green, blue}, 8'hFC);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rgb", {red, green, blue}, 8'h00);
    chk("async_rst_strobes", {hit_pulse, miss_pulse, score}, 10'd0);
    repeat (2) cyc();
    chk("rst_no_miss", miss_pulse, 1'b0);
    rst_n = 1'b1;
    cyc();

    // Lane 0 hit at y=441 after 205 frames, then 8 frames of flash
    spawn = 4'b0001;
    cyc();
    spawn = '0;
    frames(205);
    key[0] = 1'b1;
    cyc();
    chk("hit_pulse", hit_pulse, 1'b1);
    chk("hit_no_miss", miss_pulse, 1'b0);
    chk("hit_score", score, 8'd1);
    cyc();
    chk("hit_pulse_one_cycle", hit_pulse, 1'b0);
    hc = 10'd170; vc = 10'd440;
    cyc();
    chk("flash_start", {red, green, blue}, 8'hFF);
    frames(7);
    chk("flash_frame7", {red, green, blue}, 8'hFF);
    frames(1);
    chk("flash_done", {red, green, blue}, 8'h6D);
    key = '0;

    // Lane 1 spawn coincident with frame_tick: no advance; then miss on tick 213
    spawn = 4'b0010; frame_tick = 1'b1;
    cyc();
    spawn = '0; frame_tick = 1'b0;
    hc = 10'd230; vc = 10'd31;
    cyc();
    chk("spawn_tick_top", {red, green, blue}, 8'h1C);
    saw_miss = 1'b0;
    frames(212);
    chk("no_early_miss", saw_miss, 1'b0);
    frame_tick = 1'b1;
    cyc();
    chk("miss_pulse", miss_pulse, 1'b1);
    chk("miss_score", score, 8'd1);
    frame_tick = 1'b0;
    hc = 10'd230; vc = 10'd450;
    cyc();
    chk("miss_pulse_one_cycle", miss_pulse, 1'b0);
    chk("miss_lane_idle", {red, green, blue}, 8'h00);

    // Lane 3 at y=455: key with tick uses pre-advance y, so it hits
    spawn = 4'b1000;
    cyc();
    spawn = '0;
    frames(212);
    key[3] = 1'b1; frame_tick = 1'b1;
    cyc();
    chk("edge_tick_hit", hit_pulse, 1'b1);
    chk("edge_tick_miss", miss_pulse, 1'b0);
    chk("edge_tick_score", score, 8'd2);
    key = '0; frame_tick = 1'b0;
    hc = 10'd360; vc = 10'd442;
    cyc();
    chk("edge_tick_flash", {red, green, blue}, 8'hFF);

    // Score saturation on the fast instance
    for (int r = 0; r < 63; r++) fast_round(4'b1111);
    chk("fast_score_252", f_score, 8'd252);
    f_spawn = 4'b0011;
    cyc();
    f_spawn = '0; f_key = 4'b0011;
    cyc();
    chk("multi_hit_pulse", f_hit, 1'b1);
    chk("multi_hit_score", f_score, 8'd254);
    f_key = '0;
    cyc();
    chk("multi_hit_one_cycle", f_hit, 1'b0);
    f_tick = 1'b1;
    repeat (8) cyc();
    f_tick = 1'b0;
    f_spawn = 4'b0101;
    cyc();
    f_spawn = '0; f_key = 4'b0101;
    cyc();
    chk("sat_hit_pulse", f_hit, 1'b1);
    chk("sat_score", f_score, 8'd255);
    chk("sat_no_miss", f_miss, 1'b0);
    f_key = '0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
